prewish_loader: RTL and testbench

Upstream front end for the prewish controller path. Samples the 8-position DIP switch and the "load" pushbutton, then synchronizes and debounces the button. On each clean press it emits the DIP value as a new blink mask with a one-cycle strobe. Its STB_O/DAT_O feed the controller's mask/strobe input, replacing the hardcoded mask rotation with user input.

---
 rtl/prewish_pkg.sv | 18 +
 rtl/prewish_sync_debounce.sv | 54 +++++
 rtl/prewish_loader.sv | 94 +++++++++
 tb/tb_prewish_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prewish_pkg.sv
`default_nettype none
// ============================================================================
//  Module : prewish_pkg
//  Brief  : Shared types and widths for the prewish loader/controller path.
//  Rev    : 1.0  initial release
// ============================================================================
package prewish_pkg;

  localparam int PREWISH_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'b00,
    LD_STROBE = 2'b01,
    LD_HOLD   = 2'b10
  } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/prewish_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module : prewish_sync_debounce
//  Brief  : Two-flop synchronizer plus counter debounce for one input bit.
//  Rev    : 1.0  initial release
// ============================================================================
module prewish_sync_debounce #(
  parameter int   DEBOUNCE_BITS = 16,
  parameter logic SYNC_RST_VAL  = 1'b1,
  parameter logic ACTIVE_LOW    = 1'b1
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic i_raw,
  output logic o_level
);

  logic                     r_sync1;
  logic                     r_sync2;
  logic [DEBOUNCE_BITS-1:0] r_cnt;
  logic                     r_level;
  logic                     w_sample;
  logic                     w_mismatch;
  logic                     w_cnt_full;

  assign w_sample   = r_sync2 ^ ACTIVE_LOW;
  assign w_mismatch = w_sample != r_level;
  assign w_cnt_full = &r_cnt;

  // Toggle on the 2^DEBOUNCE_BITS-th consecutive mismatching sample.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_sync1 <= SYNC_RST_VAL;
      r_sync2 <= SYNC_RST_VAL;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_cnt_full) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/prewish_loader.sv
`default_nettype none
// ============================================================================
//  Module : prewish_loader
//  Brief  : Loads the DIP switch value as a blink mask on each clean button press.
//  Rev    : 1.0  initial release
// ============================================================================
module prewish_loader
  import prewish_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16,
  parameter int DATA_WIDTH    = PREWISH_DATA_WIDTH
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  i_button_n,
  input  logic [DATA_WIDTH-1:0] i_dip,
  output logic                  STB_O,
  output logic [DATA_WIDTH-1:0] DAT_O,
  output logic                  o_pressed
);

  logic [DATA_WIDTH-1:0] r_dip_s1;
  logic [DATA_WIDTH-1:0] r_dip_s2;
  ld_state_e             r_state;
  ld_state_e             w_state_nxt;
  logic                  r_stb;
  logic                  w_stb_nxt;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [DATA_WIDTH-1:0] w_dat_nxt;
  logic                  w_pressed;

  prewish_sync_debounce #(
    .DEBOUNCE_BITS (DEBOUNCE_BITS),
    .SYNC_RST_VAL  (1'b1),
    .ACTIVE_LOW    (1'b1)
  ) u_button (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .i_raw   (i_button_n),
    .o_level (w_pressed)
  );

  // The DIP is read only after the button debounce interval, so no debounce here.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_dip_s1 <= '0;
      r_dip_s2 <= '0;
    end else begin
      r_dip_s1 <= i_dip;
      r_dip_s2 <= r_dip_s1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= LD_IDLE;
      r_stb   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stb   <= w_stb_nxt;
      r_dat   <= w_dat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stb_nxt   = 1'b0;
    w_dat_nxt   = r_dat;
    case (r_state)
      LD_IDLE: begin
        if (w_pressed) begin
          w_dat_nxt   = r_dip_s2;
          w_stb_nxt   = 1'b1;
          w_state_nxt = LD_STROBE;
        end
      end
      LD_STROBE: w_state_nxt = LD_HOLD;
      // No auto-repeat: a debounced release is required to re-arm.
      LD_HOLD: begin
        if (!w_pressed) begin
          w_state_nxt = LD_IDLE;
        end
      end
      default: w_state_nxt = LD_IDLE;
    endcase
  end

  assign STB_O     = r_stb;
  assign DAT_O     = r_dat;
  assign o_pressed = w_pressed;

endmodule
`default_nettype wire

// File: tb/tb_prewish_loader.sv
`default_nettype none
// ============================================================================
//  Module : tb_prewish_loader
//  Brief  : Self-checking bench for prewish_loader with DEBOUNCE_BITS=3.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_prewish_loader;

  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] dip;
    int            low;
    int            rel;
    logic          exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          button_n = 1'b1;
  logic [DW-1:0] dip = '0;
  logic          stb;
  logic [DW-1:0] dat;
  logic          pressed;

  int            checks = 0;
  int            errors = 0;
  int            strobe_cnt = 0;
  logic          prev_stb = 1'b0;
  logic [DW-1:0] model_dat = '0;
  logic [DW-1:0] qexp[$];
  vec_t          vecs[8];

  prewish_loader #(
    .DEBOUNCE_BITS (3),
    .DATA_WIDTH    (DW)
  ) dut (
    .CLK_I      (clk),
    .RST_I      (rst_n),
    .i_button_n (button_n),
    .i_dip      (dip),
    .STB_O      (stb),
    .DAT_O      (dat),
    .o_pressed  (pressed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock; every cycle the strobe is matched against the scoreboard.
  task automatic tick();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (stb) begin
        strobe_cnt++;
        check("stb_one_cycle", {31'd0, prev_stb}, 32'd0);
        if (qexp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual=%0h required=none", dat);
        end else begin
          e = qexp.pop_front();
          check("strobe_dat", {24'd0, dat}, {24'd0, e});
          model_dat = e;
        end
      end else begin
        check("dat_stable", {24'd0, dat}, {24'd0, model_dat});
      end
      prev_stb = stb;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic measure(input int n, output int first, output int cnt);
    int s0;
    s0    = strobe_cnt;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (stb && first < 0) first = i;
    end
    cnt = strobe_cnt - s0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            first;
    int            cnt;
    int            s0;
    logic [DW-1:0] exp_dat;
    logic          found;

    vecs[0] = '{dip: 8'h55, low: 1,   rel: 2,  exp: 1'b0};
    vecs[1] = '{dip: 8'h55, low: 3,   rel: 2,  exp: 1'b0};
    vecs[2] = '{dip: 8'h55, low: 7,   rel: 12, exp: 1'b0};
    vecs[3] = '{dip: 8'h3C, low: 8,   rel: 12, exp: 1'b1};
    vecs[4] = '{dip: 8'hFF, low: 15,  rel: 12, exp: 1'b1};
    vecs[5] = '{dip: 8'hFF, low: 15,  rel: 12, exp: 1'b1};
    vecs[6] = '{dip: 8'h96, low: 100, rel: 12, exp: 1'b1};
    vecs[7] = '{dip: 8'h21, low: 2,   rel: 12, exp: 1'b0};

    ticks(3);
    check("rst_stb", {31'd0, stb}, 32'd0);
    check("rst_dat", {24'd0, dat}, 32'd0);
    check("rst_pressed", {31'd0, pressed}, 32'd0);
    rst_n = 1'b1;

    // Test 1: press latency and single strobe
    dip      = 8'hA8;
    button_n = 1'b0;
    qexp.push_back(8'hA8);
    measure(20, first, cnt);
    check("t1_latency", first, 32'd11);
    check("t1_count", cnt, 32'd1);
    check("t1_pressed", {31'd0, pressed}, 32'd1);
    check("t1_dat", {24'd0, dat}, 32'hA8);

    // Test 2: DIP change while held is ignored until the next press
    dip = 8'hCA;
    ticks(5);
    check("t2_dat_held", {24'd0, dat}, 32'hA8);
    button_n = 1'b1;
    ticks(12);
    check("t2_released", {31'd0, pressed}, 32'd0);
    check("t2_dat_idle", {24'd0, dat}, 32'hA8);
    button_n = 1'b0;
    qexp.push_back(8'hCA);
    measure(20, first, cnt);
    check("t2_count", cnt, 32'd1);
    check("t2_dat", {24'd0, dat}, 32'hCA);
    button_n = 1'b1;
    ticks(12);

    // Table: glitches, interval boundary, repeated value, long hold
    exp_dat = 8'hCA;
    foreach (vecs[k]) begin
      s0       = strobe_cnt;
      dip      = vecs[k].dip;
      button_n = 1'b0;
      if (vecs[k].exp) begin
        qexp.push_back(vecs[k].dip);
        exp_dat = vecs[k].dip;
      end
      ticks(vecs[k].low);
      button_n = 1'b1;
      ticks(vecs[k].rel);
      check($sformatf("vec%0d_strobes", k), strobe_cnt - s0, {31'd0, vecs[k].exp});
      check($sformatf("vec%0d_dat", k), {24'd0, dat}, {24'd0, exp_dat});
      if (vecs[k].rel >= 12)
        check($sformatf("vec%0d_pressed", k), {31'd0, pressed}, 32'd0);
    end

    // Test 4: release bounce in HOLD does not re-arm early
    dip      = 8'h5A;
    button_n = 1'b0;
    qexp.push_back(8'h5A);
    ticks(30);
    s0 = strobe_cnt;
    for (int i = 0; i < 5; i++) begin
      button_n = ~i[0];
      tick();
    end
    button_n = 1'b0;
    ticks(20);
    check("t4_still_pressed", {31'd0, pressed}, 32'd1);
    check("t4_no_repeat", strobe_cnt - s0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      button_n = ~i[0];
      tick();
    end
    button_n = 1'b1;
    tick();
    check("t4_bounce_pressed", {31'd0, pressed}, 32'd1);
    ticks(12);
    check("t4_released", {31'd0, pressed}, 32'd0);
    check("t4_no_strobe", strobe_cnt - s0, 32'd0);
    dip      = 8'hA5;
    button_n = 1'b0;
    qexp.push_back(8'hA5);
    measure(20, first, cnt);
    check("t4_repress", cnt, 32'd1);
    check("t4_dat", {24'd0, dat}, 32'hA5);
    button_n = 1'b1;
    ticks(12);

    // Test 5: reset while STB_O is high
    dip      = 8'h3C;
    button_n = 1'b0;
    qexp.push_back(8'h3C);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (stb) found = 1'b1;
    end
    check("t5_strobe_seen", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_stb", {31'd0, stb}, 32'd0);
    check("t5_rst_dat", {24'd0, dat}, 32'd0);
    check("t5_rst_pressed", {31'd0, pressed}, 32'd0);
    qexp.delete();
    model_dat = '0;
    prev_stb  = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    qexp.push_back(8'h3C);
    measure(20, first, cnt);
    check("t5_latency", first, 32'd11);
    check("t5_count", cnt, 32'd1);
    button_n = 1'b1;
    ticks(12);

    check("queue_empty", qexp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
